// File: rtl/alu_rsv_station_pkg.sv
// Shared widths, bus types and the reservation-station entry layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_rsv_station_pkg;

    localparam int OP_ID_W  = 6;
    localparam int ROB_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;

    typedef logic [OP_ID_W-1:0]  op_id_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [RS_IDX_W-1:0] rs_idx_t;

    // One reservation-station slot. vj/vk hold the operand value once the
    // matching q*_busy flag is clear.
    typedef struct packed {
        logic    busy;
        op_id_t  op;
        data_t   pc;
        data_t   vj;
        logic    qj_busy;
        rob_id_t qj;
        data_t   vk;
        logic    qk_busy;
        rob_id_t qk;
        data_t   imm;
        rob_id_t rob_id;
    } rs_entry_t;

    // True when a valid broadcast carries the tag an operand is waiting on.
    function automatic logic cdb_hit(input logic vld, input rob_id_t tag, input rob_id_t want);
        return vld && (tag == want);
    endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// Find-first-set: reports whether any request bit is set and the lowest index.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req_i (request vector), found_o (any bit set), idx_o (lowest set index).
module rs_pick_lowest #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB result buses, issues one ready op per cycle.
// Latency: dispatch with ready operands -> alu_valid one cycle later; wakeup -> issue one cycle later.
// Backpressure: none toward the ALU; dispatcher must honour full (dispatch while full is dropped).
// Ports: clk/rst/rdy/flush control; disp_* dispatch request; alu_cdb_*/lsb_cdb_* result
// broadcasts; full status; alu_* registered issue bundle to the ALU.
module alu_rsv_station
    import alu_rsv_station_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                disp_valid,
    input  logic [OP_ID_W-1:0]  disp_op_id,
    input  logic [DATA_W-1:0]   disp_pc,
    input  logic [DATA_W-1:0]   disp_vj,
    input  logic                disp_qj_busy,
    input  logic [ROB_ID_W-1:0] disp_qj,
    input  logic [DATA_W-1:0]   disp_vk,
    input  logic                disp_qk_busy,
    input  logic [ROB_ID_W-1:0] disp_qk,
    input  logic [DATA_W-1:0]   disp_imm,
    input  logic [ROB_ID_W-1:0] disp_rob_id,
    output logic                full,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  logic [DATA_W-1:0]   alu_cdb_value,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
    input  logic [DATA_W-1:0]   lsb_cdb_value,
    output logic                alu_valid,
    output logic [OP_ID_W-1:0]  alu_op_id,
    output logic [DATA_W-1:0]   alu_pc,
    output logic [DATA_W-1:0]   alu_rs1,
    output logic [DATA_W-1:0]   alu_rs2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [ROB_ID_W-1:0] alu_rob_id
);

    rs_entry_t rs_q [RS_SIZE];
    rs_entry_t rs_d [RS_SIZE];

    logic    alu_valid_q, alu_valid_d;
    op_id_t  alu_op_id_q, alu_op_id_d;
    data_t   alu_pc_q, alu_pc_d;
    data_t   alu_rs1_q, alu_rs1_d;
    data_t   alu_rs2_q, alu_rs2_d;
    data_t   alu_imm_q, alu_imm_d;
    rob_id_t alu_rob_id_q, alu_rob_id_d;

    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic               free_found, ready_found;
    rs_idx_t            free_idx, ready_idx;
    rs_entry_t          new_ent;

    // Both searches look only at registered state, so a slot issuing this
    // cycle is still seen as busy and cannot be reused until next cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !rs_q[i].busy;
            ready_vec[i] = rs_q[i].busy && !rs_q[i].qj_busy && !rs_q[i].qk_busy;
        end
    end

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_free (
        .req_i   (free_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_ready (
        .req_i   (ready_vec),
        .found_o (ready_found),
        .idx_o   (ready_idx)
    );

    assign full = !free_found;

    // Incoming entry, with same-cycle broadcast forwarding. ALU bus wins a tie.
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = disp_op_id;
        new_ent.pc      = disp_pc;
        new_ent.imm     = disp_imm;
        new_ent.rob_id  = disp_rob_id;
        new_ent.vj      = disp_vj;
        new_ent.qj_busy = disp_qj_busy;
        new_ent.qj      = disp_qj;
        new_ent.vk      = disp_vk;
        new_ent.qk_busy = disp_qk_busy;
        new_ent.qk      = disp_qk;
        if (disp_qj_busy) begin
            if (cdb_hit(alu_cdb_valid, alu_cdb_rob_id, disp_qj)) begin
                new_ent.vj      = alu_cdb_value;
                new_ent.qj_busy = 1'b0;
            end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob_id, disp_qj)) begin
                new_ent.vj      = lsb_cdb_value;
                new_ent.qj_busy = 1'b0;
            end
        end
        if (disp_qk_busy) begin
            if (cdb_hit(alu_cdb_valid, alu_cdb_rob_id, disp_qk)) begin
                new_ent.vk      = alu_cdb_value;
                new_ent.qk_busy = 1'b0;
            end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob_id, disp_qk)) begin
                new_ent.vk      = lsb_cdb_value;
                new_ent.qk_busy = 1'b0;
            end
        end
    end

    always_comb begin
        rs_d         = rs_q;
        alu_valid_d  = 1'b0;
        alu_op_id_d  = alu_op_id_q;
        alu_pc_d     = alu_pc_q;
        alu_rs1_d    = alu_rs1_q;
        alu_rs2_d    = alu_rs2_q;
        alu_imm_d    = alu_imm_q;
        alu_rob_id_d = alu_rob_id_q;

        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_d[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].busy && rs_q[i].qj_busy) begin
                    if (cdb_hit(alu_cdb_valid, alu_cdb_rob_id, rs_q[i].qj)) begin
                        rs_d[i].vj      = alu_cdb_value;
                        rs_d[i].qj_busy = 1'b0;
                    end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob_id, rs_q[i].qj)) begin
                        rs_d[i].vj      = lsb_cdb_value;
                        rs_d[i].qj_busy = 1'b0;
                    end
                end
                if (rs_q[i].busy && rs_q[i].qk_busy) begin
                    if (cdb_hit(alu_cdb_valid, alu_cdb_rob_id, rs_q[i].qk)) begin
                        rs_d[i].vk      = alu_cdb_value;
                        rs_d[i].qk_busy = 1'b0;
                    end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob_id, rs_q[i].qk)) begin
                        rs_d[i].vk      = lsb_cdb_value;
                        rs_d[i].qk_busy = 1'b0;
                    end
                end
            end

            if (ready_found) begin
                alu_valid_d            = 1'b1;
                alu_op_id_d            = rs_q[ready_idx].op;
                alu_pc_d               = rs_q[ready_idx].pc;
                alu_rs1_d              = rs_q[ready_idx].vj;
                alu_rs2_d              = rs_q[ready_idx].vk;
                alu_imm_d              = rs_q[ready_idx].imm;
                alu_rob_id_d           = rs_q[ready_idx].rob_id;
                rs_d[ready_idx].busy   = 1'b0;
            end

            // free_idx never equals ready_idx: a ready slot is busy.
            if (disp_valid && free_found) begin
                rs_d[free_idx] = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_q[i] <= '0;
            end
            alu_valid_q  <= 1'b0;
            alu_op_id_q  <= '0;
            alu_pc_q     <= '0;
            alu_rs1_q    <= '0;
            alu_rs2_q    <= '0;
            alu_imm_q    <= '0;
            alu_rob_id_q <= '0;
        end else if (rdy) begin
            rs_q         <= rs_d;
            alu_valid_q  <= alu_valid_d;
            alu_op_id_q  <= alu_op_id_d;
            alu_pc_q     <= alu_pc_d;
            alu_rs1_q    <= alu_rs1_d;
            alu_rs2_q    <= alu_rs2_d;
            alu_imm_q    <= alu_imm_d;
            alu_rob_id_q <= alu_rob_id_d;
        end
    end

    assign alu_valid  = alu_valid_q;
    assign alu_op_id  = alu_op_id_q;
    assign alu_pc     = alu_pc_q;
    assign alu_rs1    = alu_rs1_q;
    assign alu_rs2    = alu_rs2_q;
    assign alu_imm    = alu_imm_q;
    assign alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: directed scenarios plus a random phase,
// every cycle compared against a slot-array reference model.
// Latency/backpressure: n/a.
module tb_alu_rsv_station;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        disp_valid;
    logic [5:0]  disp_op_id;
    logic [31:0] disp_pc, disp_vj, disp_vk, disp_imm;
    logic        disp_qj_busy, disp_qk_busy;
    logic [3:0]  disp_qj, disp_qk, disp_rob_id;
    logic        full;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic        alu_valid;
    logic [5:0]  alu_op_id;
    logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
    logic [3:0]  alu_rob_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_rsv_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_op_id(disp_op_id), .disp_pc(disp_pc),
        .disp_vj(disp_vj), .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
        .disp_vk(disp_vk), .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk),
        .disp_imm(disp_imm), .disp_rob_id(disp_rob_id), .full(full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .alu_valid(alu_valid), .alu_op_id(alu_op_id), .alu_pc(alu_pc),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
    );

    // Reference model: one record per slot, filled lowest free first.
    logic        m_busy [16];
    logic [5:0]  m_op   [16];
    logic [31:0] m_pc [16], m_vj [16], m_vk [16], m_imm [16];
    logic        m_qjb [16], m_qkb [16];
    logic [3:0]  m_qj [16], m_qk [16], m_rob [16];
    logic        e_valid;
    logic [5:0]  e_op;
    logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
    logic [3:0]  e_rob;

    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Resolve a waiting operand against this cycle's broadcasts (ALU bus first).
    task automatic resolve(inout logic pend, input logic [3:0] tag, inout logic [31:0] val);
        if (pend) begin
            if (alu_cdb_valid && alu_cdb_rob_id == tag) begin
                val = alu_cdb_value; pend = 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == tag) begin
                val = lsb_cdb_value; pend = 1'b0;
            end
        end
    endtask

    function automatic logic model_full();
        for (int i = 0; i < 16; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int ri, fi;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            e_valid = 1'b0; e_op = '0; e_pc = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rob = '0;
        end else if (!rdy) begin
            // frozen
        end else if (flush) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            e_valid = 1'b0;
        end else begin
            ri = -1; fi = -1;
            for (int i = 0; i < 16; i++) begin
                if (ri < 0 && m_busy[i] && !m_qjb[i] && !m_qkb[i]) ri = i;
                if (fi < 0 && !m_busy[i]) fi = i;
            end
            if (ri >= 0) begin
                e_valid = 1'b1; e_op = m_op[ri]; e_pc = m_pc[ri]; e_rs1 = m_vj[ri];
                e_rs2 = m_vk[ri]; e_imm = m_imm[ri]; e_rob = m_rob[ri];
                m_busy[ri] = 1'b0;
            end else begin
                e_valid = 1'b0;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_busy[i]) begin
                    resolve(m_qjb[i], m_qj[i], m_vj[i]);
                    resolve(m_qkb[i], m_qk[i], m_vk[i]);
                end
            end
            if (disp_valid && fi >= 0) begin
                m_busy[fi] = 1'b1; m_op[fi] = disp_op_id; m_pc[fi] = disp_pc;
                m_imm[fi] = disp_imm; m_rob[fi] = disp_rob_id;
                m_vj[fi] = disp_vj; m_qjb[fi] = disp_qj_busy; m_qj[fi] = disp_qj;
                m_vk[fi] = disp_vk; m_qkb[fi] = disp_qk_busy; m_qk[fi] = disp_qk;
                resolve(m_qjb[fi], m_qj[fi], m_vj[fi]);
                resolve(m_qkb[fi], m_qk[fi], m_vk[fi]);
            end
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("alu_valid", 32'(alu_valid), 32'(e_valid));
        chk("full", 32'(full), 32'(model_full()));
        chk("alu_op_id", 32'(alu_op_id), 32'(e_op));
        chk("alu_pc", alu_pc, e_pc);
        chk("alu_rs1", alu_rs1, e_rs1);
        chk("alu_rs2", alu_rs2, e_rs2);
        chk("alu_imm", alu_imm, e_imm);
        chk("alu_rob_id", 32'(alu_rob_id), 32'(e_rob));
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] vj,
                        input logic qjb, input logic [3:0] qj, input logic [31:0] vk,
                        input logic qkb, input logic [3:0] qk, input logic [31:0] imm,
                        input logic [3:0] rob);
        disp_valid = 1'b1; disp_op_id = op; disp_pc = pc; disp_vj = vj; disp_qj_busy = qjb;
        disp_qj = qj; disp_vk = vk; disp_qk_busy = qkb; disp_qk = qk; disp_imm = imm;
        disp_rob_id = rob;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        disp_op_id = '0; disp_pc = '0; disp_vj = '0; disp_qj_busy = 1'b0; disp_qj = '0;
        disp_vk = '0; disp_qk_busy = 1'b0; disp_qk = '0; disp_imm = '0; disp_rob_id = '0;
        alu_cdb_rob_id = '0; alu_cdb_value = '0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 1'b0; m_qjb[i] = 1'b0; m_qkb[i] = 1'b0;
        end
        step();
        step();
        chk("reset_valid", 32'(alu_valid), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rob_id", 32'(alu_rob_id), 32'd0);

        // Ready dispatch: one-cycle latency, one-cycle pulse.
        idle();
        disp(OP_ADDI, 32'h100, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7, 4'd3);
        step();
        chk("ready_disp_not_yet", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("ready_disp_valid", 32'(alu_valid), 32'd1);
        chk("ready_disp_op", 32'(alu_op_id), 32'(OP_ADDI));
        chk("ready_disp_rs1", alu_rs1, 32'd5);
        chk("ready_disp_imm", alu_imm, 32'd7);
        chk("ready_disp_rob", 32'(alu_rob_id), 32'd3);
        step();
        chk("ready_disp_pulse", 32'(alu_valid), 32'd0);

        // Wakeup from LSB bus.
        disp(OP_ADD, 32'h104, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 32'd0, 4'd4);
        step();
        idle();
        step();
        chk("wakeup_waiting", 32'(alu_valid), 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_value = 32'h10;
        step();
        chk("wakeup_capture_cycle", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("wakeup_valid", 32'(alu_valid), 32'd1);
        chk("wakeup_rs1", alu_rs1, 32'h10);
        chk("wakeup_rs2", alu_rs2, 32'd1);

        // Dispatch forwarding from the ALU bus.
        disp(OP_BEQ, 32'h108, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hFFFF_FFF8, 4'd5);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd6; alu_cdb_value = 32'd9;
        step();
        idle();
        step();
        chk("fwd_valid", 32'(alu_valid), 32'd1);
        chk("fwd_rs2", alu_rs2, 32'd9);
        step();

        // Fill all 16 slots with entries waiting on tag 5.
        for (int i = 0; i < 16; i++) begin
            disp(OP_ADD, 32'(i * 4), 32'd0, 1'b1, 4'd5, 32'(i), 1'b0, 4'd0, 32'd0, 4'(i));
            step();
            if (i == 14) chk("fill_not_full_15", 32'(full), 32'd0);
        end
        chk("fill_full_16", 32'(full), 32'd1);
        disp(OP_ADDI, 32'h200, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd3, 4'hE);
        step();
        chk("drop_when_full", 32'(alu_valid), 32'd0);
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd5; alu_cdb_value = 32'hAA;
        step();
        idle();
        for (int i = 0; i < 16; i++) begin
            step();
            chk("order_valid", 32'(alu_valid), 32'd1);
            chk("order_rob", 32'(alu_rob_id), 32'(i));
            chk("order_rs1", alu_rs1, 32'hAA);
            if (i == 0) chk("full_drops", 32'(full), 32'd0);
        end
        step();
        chk("order_drained", 32'(alu_valid), 32'd0);

        // Flush with three waiting entries and a discarded same-cycle dispatch.
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'h300, 32'd0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0, 4'(8 + i));
            step();
        end
        idle();
        flush = 1'b1;
        disp(OP_ADDI, 32'h400, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd1);
        step();
        chk("flush_valid", 32'(alu_valid), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_value = 32'h77;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_issue", 32'(alu_valid), 32'd0);
        end

        // rdy stall holds the issue bundle; inputs are ignored meanwhile.
        disp(OP_ADDI, 32'h500, 32'd11, 1'b0, 4'd0, 32'd12, 1'b0, 4'd0, 32'd13, 4'd1);
        step();
        disp(OP_ADD, 32'h504, 32'd21, 1'b0, 4'd0, 32'd22, 1'b0, 4'd0, 32'd23, 4'd2);
        step();
        chk("stall_pre_rob", 32'(alu_rob_id), 32'd1);
        rdy = 1'b0;
        disp(OP_BEQ, 32'h508, 32'd31, 1'b0, 4'd0, 32'd32, 1'b0, 4'd0, 32'd33, 4'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(alu_valid), 32'd1);
            chk("stall_rob", 32'(alu_rob_id), 32'd1);
            chk("stall_rs1", alu_rs1, 32'd11);
        end
        idle();
        step();
        chk("resume_rob", 32'(alu_rob_id), 32'd2);
        chk("resume_rs1", alu_rs1, 32'd21);
        step();
        chk("resume_done", 32'(alu_valid), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rdy           = ($urandom % 8) != 0;
            flush         = ($urandom % 50) == 0;
            disp_valid    = ($urandom % 2) == 0;
            disp_op_id    = 6'($urandom);
            disp_pc       = $urandom;
            disp_vj       = $urandom;
            disp_vk       = $urandom;
            disp_imm      = $urandom;
            disp_qj_busy  = ($urandom % 2) == 0;
            disp_qk_busy  = ($urandom % 3) == 0;
            disp_qj       = 4'($urandom_range(0, 7));
            disp_qk       = 4'($urandom_range(0, 7));
            disp_rob_id   = 4'($urandom);
            alu_cdb_valid = ($urandom % 3) == 0;
            alu_cdb_rob_id = 4'($urandom_range(0, 7));
            alu_cdb_value = $urandom;
            lsb_cdb_valid = ($urandom % 3) == 0;
            lsb_cdb_rob_id = 4'($urandom_range(0, 7));
            lsb_cdb_value = $urandom;
            step();
        end

        // Reset mid-traffic returns everything to idle.
        idle();
        rst = 1'b1;
        step();
        chk("final_reset_valid", 32'(alu_valid), 32'd0);
        chk("final_reset_full", 32'(full), 32'd0);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
